// File: rtl/kat_adc_iic_pkg.sv
// Shared constants and state type for the IIC GPIO-expander gain sequencer.
// Step encoding of one channel write: 0..2 program output-enable, 3..5 write the gain.
package kat_adc_iic_pkg;
  localparam logic [7:0] GPIO_REG_OEN = 8'h06;
  localparam logic [7:0] GPIO_REG_OUT = 8'h02;
  localparam logic       IIC_WR       = 1'b0;
  localparam logic [2:0] STEP_OEN_END = 3'd2;
  localparam logic [2:0] STEP_OUT     = 3'd3;
  localparam logic [2:0] STEP_LAST    = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} gs_state_e;
endpackage

// File: rtl/gain_byte_gen.sv
// Combinational byte/flag generator for one step of a channel's 6-byte IIC write.
module gain_byte_gen
  import kat_adc_iic_pkg::*;
#(
  parameter int GAIN_W = 7
) (
  input  logic [2:0]        step_i,
  input  logic [6:0]        addr_i,
  input  logic [GAIN_W-1:0] gain_i,
  input  logic              last_i,
  output logic [7:0]        data_o,
  output logic              start_o,
  output logic              stop_o,
  output logic              rnw_o,
  output logic              lock_o
);
  logic [7:0] gain_byte;

  // MSB of the gain lands on bit 7, bit 6 is forced high, the rest right-aligned.
  always_comb begin
    gain_byte    = 8'h40;
    gain_byte[7] = gain_i[GAIN_W-1];
    for (int i = 0; i < GAIN_W-1; i++) gain_byte[i] = gain_i[i];
  end

  always_comb begin
    data_o  = 8'h00;
    start_o = 1'b0;
    stop_o  = 1'b0;
    case (step_i)
      3'd0, 3'd3: begin data_o = {addr_i, IIC_WR}; start_o = 1'b1; end
      3'd1:       data_o = GPIO_REG_OEN;
      3'd2:       begin data_o = 8'h00; stop_o = 1'b1; end
      3'd4:       data_o = GPIO_REG_OUT;
      3'd5:       begin data_o = gain_byte; stop_o = 1'b1; end
      default:    ;
    endcase
  end

  assign rnw_o  = IIC_WR;
  assign lock_o = !last_i;
endmodule

// File: rtl/gain_set_multi.sv
// Sequencer that writes per-channel gains to GPIO expanders through a byte-wide
// IIC transaction queue, with a one-deep last-wins pending request slot.
module gain_set_multi
  import kat_adc_iic_pkg::*;
#(
  parameter int         NUM_CH    = 2,
  parameter int         GAIN_W    = 7,
  parameter logic [6:0] BASE_ADDR = 7'h20,
  parameter bit         OEN_ONCE  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*GAIN_W-1:0] gain_value,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     gain_load,
  output logic                     busy,
  output logic                     done,
  output logic                     trans_vld,
  input  logic                     trans_rdy,
  output logic [7:0]               trans_data,
  output logic                     trans_start,
  output logic                     trans_stop,
  output logic                     trans_rnw,
  output logic                     trans_lock
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GV_W = NUM_CH*GAIN_W;

  gs_state_e         state_q, state_d;
  logic [GV_W-1:0]   gain_q, gain_d, pgain_q, pgain_d;
  logic [NUM_CH-1:0] mask_q, mask_d, pmask_q, pmask_d, cfg_q, cfg_d;
  logic              pend_q, pend_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [2:0]        step_q, step_d;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] m, input int from);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (m[i] && i >= from) r = {1'b1, CH_W'(i)};
    return r;
  endfunction

  function automatic logic [2:0] start_step(input logic [NUM_CH-1:0] cfg, input logic [CH_W-1:0] c);
    return (OEN_ONCE && cfg[c]) ? STEP_OUT : 3'd0;
  endfunction

  logic                run, acc, last_byte, ld_go;
  logic [CH_W:0]       nxt, first;
  logic [NUM_CH-1:0]   ld_mask;
  logic [GV_W-1:0]     ld_gain;

  assign run       = (state_q == ST_RUN);
  assign acc       = run && trans_rdy;
  assign nxt       = find_ch(mask_q, int'(ch_q) + 1);
  assign last_byte = (step_q == STEP_LAST) && !nxt[CH_W];

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    mask_d  = mask_q;
    pgain_d = pgain_q;
    pmask_d = pmask_q;
    pend_d  = pend_q;
    cfg_d   = cfg_q;
    ch_d    = ch_q;
    step_d  = step_q;
    ld_go   = 1'b0;
    ld_mask = ch_mask;
    ld_gain = gain_value;
    first   = '0;
    case (state_q)
      ST_IDLE: ld_go = gain_load;
      ST_RUN: begin
        if (gain_load) begin
          pend_d  = 1'b1;
          pgain_d = gain_value;
          pmask_d = ch_mask;
        end
        if (acc) begin
          if (step_q == STEP_OEN_END) cfg_d[ch_q] = 1'b1;
          if (step_q != STEP_LAST) step_d = step_q + 3'd1;
          else if (nxt[CH_W]) begin
            ch_d   = nxt[CH_W-1:0];
            step_d = start_step(cfg_q, nxt[CH_W-1:0]);
          end else state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        // A load arriving in FIN is newer than the slot, so it wins outright.
        if (gain_load || pend_q) begin
          ld_go  = 1'b1;
          pend_d = 1'b0;
          if (!gain_load) begin
            ld_mask = pmask_q;
            ld_gain = pgain_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ld_go) begin
      gain_d  = ld_gain;
      mask_d  = ld_mask;
      first   = find_ch(ld_mask, 0);
      state_d = first[CH_W] ? ST_RUN : ST_FIN;
      ch_d    = first[CH_W-1:0];
      step_d  = start_step(cfg_q, first[CH_W-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gain_q  <= '0;
      mask_q  <= '0;
      pgain_q <= '0;
      pmask_q <= '0;
      pend_q  <= 1'b0;
      cfg_q   <= '0;
      ch_q    <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      mask_q  <= mask_d;
      pgain_q <= pgain_d;
      pmask_q <= pmask_d;
      pend_q  <= pend_d;
      cfg_q   <= cfg_d;
      ch_q    <= ch_d;
      step_q  <= step_d;
    end
  end

  logic [6:0]        ch_addr;
  logic [GAIN_W-1:0] ch_gain;
  logic [7:0]        gen_data;
  logic              gen_start, gen_stop, gen_rnw, gen_lock;

  assign ch_addr = BASE_ADDR + 7'(ch_q);
  assign ch_gain = gain_q[int'(ch_q)*GAIN_W +: GAIN_W];

  gain_byte_gen #(.GAIN_W(GAIN_W)) u_gen (
    .step_i  (step_q),
    .addr_i  (ch_addr),
    .gain_i  (ch_gain),
    .last_i  (last_byte),
    .data_o  (gen_data),
    .start_o (gen_start),
    .stop_o  (gen_stop),
    .rnw_o   (gen_rnw),
    .lock_o  (gen_lock)
  );

  assign trans_vld   = run;
  assign trans_data  = run ? gen_data : 8'h00;
  assign trans_start = run && gen_start;
  assign trans_stop  = run && gen_stop;
  assign trans_lock  = run && gen_lock;
  assign trans_rnw   = gen_rnw;
  assign done        = (state_q == ST_FIN);
  assign busy        = (state_q != ST_IDLE) || pend_q;
endmodule

// File: tb/tb_gain_set_multi.sv
// Random-stimulus bench: two instances (OEN every time / OEN once) against a byte-stream model.
module tb_gain_set_multi;
  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] gain_value;
  logic [1:0]  ch_mask;
  logic        gain_load, trans_rdy;
  logic        busy[2], done[2], vld[2], start[2], stop[2], rnw[2], lock[2];
  logic [7:0]  data[2];

  gain_set_multi #(.NUM_CH(2), .GAIN_W(7), .BASE_ADDR(7'h20), .OEN_ONCE(1'b0)) u0 (
    .clk(clk), .rst(rst), .gain_value(gain_value), .ch_mask(ch_mask), .gain_load(gain_load),
    .busy(busy[0]), .done(done[0]), .trans_vld(vld[0]), .trans_rdy(trans_rdy),
    .trans_data(data[0]), .trans_start(start[0]), .trans_stop(stop[0]),
    .trans_rnw(rnw[0]), .trans_lock(lock[0]));

  gain_set_multi #(.NUM_CH(2), .GAIN_W(7), .BASE_ADDR(7'h20), .OEN_ONCE(1'b1)) u1 (
    .clk(clk), .rst(rst), .gain_value(gain_value), .ch_mask(ch_mask), .gain_load(gain_load),
    .busy(busy[1]), .done(done[1]), .trans_vld(vld[1]), .trans_rdy(trans_rdy),
    .trans_data(data[1]), .trans_start(start[1]), .trans_stop(stop[1]),
    .trans_rnw(rnw[1]), .trans_lock(lock[1]));

  always #5 clk = ~clk;

  typedef logic [11:0] ent_t; // {lock, start, stop, rnw, data}
  ent_t expq[2][$];
  ent_t actq[2][$];
  bit   mcfg[2][2];
  int   checks = 0, fails = 0;
  int   cyc = 0, lcyc = 0;
  int   dn[2], lacc[2], dcyc[2];
  bit   zm = 1'b0, rnd_rdy = 1'b0;
  bit   pstall[2];
  ent_t pent[2];
  ent_t e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Expected bytes per instance: full 6-byte write, or the last 3 only when OEN was already done.
  function automatic void model(input logic [1:0] m, input logic [13:0] g);
    ent_t       s[$];
    ent_t       t;
    logic [7:0] a;
    logic [6:0] gc;
    for (int d = 0; d < 2; d++) begin
      s.delete();
      for (int c = 0; c < 2; c++) begin
        if (m[c]) begin
          a  = 8'((32'h20 + c) * 2);
          gc = g[c*7 +: 7];
          if (!(d == 1 && mcfg[d][c])) begin
            s.push_back({4'b1100, a});
            s.push_back({4'b1000, 8'h06});
            s.push_back({4'b1010, 8'h00});
          end
          mcfg[d][c] = 1'b1;
          s.push_back({4'b1100, a});
          s.push_back({4'b1000, 8'h02});
          s.push_back({4'b1010, gc[6], 1'b1, gc[5:0]});
        end
      end
      if (s.size() > 0) begin
        t = s.pop_back();
        t[11] = 1'b0;
        s.push_back(t);
      end
      foreach (s[i]) expq[d].push_back(s[i]);
    end
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) pstall[d] = 1'b0;
      else begin
        e = {lock[d], start[d], stop[d], rnw[d], data[d]};
        if (pstall[d]) chk("stall_hold", {vld[d], e}, {1'b1, pent[d]});
        if (vld[d] && trans_rdy) begin
          actq[d].push_back(e);
          lacc[d] = cyc;
        end
        if (done[d]) begin
          dn[d]++;
          dcyc[d] = cyc;
          if (!zm) chk("done_lat", cyc - lacc[d], 1);
        end
        pstall[d] = vld[d] && !trans_rdy;
        pent[d]   = e;
      end
    end
  end

  initial begin
    trans_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      trans_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic load(input logic [1:0] m, input logic [13:0] g);
    @(posedge clk); #1;
    gain_value = g; ch_mask = m; gain_load = 1'b1; lcyc = cyc;
    @(posedge clk); #1;
    gain_load = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while ((dn[0] < n || dn[1] < n) && t < 2000) begin @(negedge clk); t++; end
    chk("done_seen", 32'(dn[0] >= n && dn[1] >= n), 1);
    repeat (3) @(negedge clk);
    chk("done_cnt0", dn[0], n);
    chk("done_cnt1", dn[1], n);
  endtask

  task automatic cmp(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_len"}, actq[d].size(), expq[d].size());
      for (int i = 0; i < expq[d].size() && i < actq[d].size(); i++) chk(tag, actq[d][i], expq[d][i]);
      actq[d].delete();
      expq[d].delete();
    end
    dn[0] = 0; dn[1] = 0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] g;
    logic [1:0]  m;
    int          t, bad;
    rst = 1'b1; gain_load = 1'b0; gain_value = '0; ch_mask = '0;
    dn[0] = 0; dn[1] = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk("rst_out", {vld[d], done[d], busy[d], lock[d], start[d], stop[d], data[d]}, 0);
    @(posedge clk); #1 rst = 1'b0;

    model(2'b11, 14'h3FFF); load(2'b11, 14'h3FFF); wait_done(1); cmp("seq_all");
    model(2'b10, {7'h05, 7'h00}); load(2'b10, {7'h05, 7'h00}); wait_done(1); cmp("seq_ch1");
    g = 14'($urandom);
    model(2'b01, g); load(2'b01, g); wait_done(1); cmp("oen_once");

    rnd_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      m = 2'($urandom_range(1, 3));
      g = 14'($urandom);
      model(m, g); load(m, g); wait_done(1); cmp("rand");
    end

    // Empty mask: no bytes, done one cycle after the load.
    rnd_rdy = 1'b0; zm = 1'b1;
    load(2'b00, 14'h1234); wait_done(1);
    chk("zm_lat0", dcyc[0] - lcyc, 1);
    chk("zm_lat1", dcyc[1] - lcyc, 1);
    cmp("zm");
    zm = 1'b0;

    // Three loads back to back: the middle one is overwritten by the last.
    rnd_rdy = 1'b1;
    model(2'b11, 14'h0081);
    model(2'b11, 14'h0183);
    load(2'b11, 14'h0081); load(2'b11, 14'h0102); load(2'b11, 14'h0183);
    bad = 0; t = 0;
    while ((dn[0] < 2 || dn[1] < 2) && t < 2000) begin
      @(negedge clk); t++;
      for (int d = 0; d < 2; d++) if (dn[d] < 2 && !busy[d]) bad++;
    end
    chk("busy_hold", bad, 0);
    wait_done(2); cmp("pend");

    // Reset mid-sequence: abandoned, no done, and OEN is replayed afterwards.
    rnd_rdy = 1'b0;
    g = 14'($urandom);
    load(2'b11, g);
    t = 0;
    while (actq[0].size() < 4 && t < 200) begin @(negedge clk); t++; end
    chk("rst_reach4", 32'(actq[0].size() >= 4), 1);
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_vld", vld[d], 0);
      chk("rst_busy", busy[d], 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_nodone0", dn[0], 0);
    chk("rst_nodone1", dn[1], 0);
    for (int d = 0; d < 2; d++) begin
      actq[d].delete(); expq[d].delete();
      mcfg[d][0] = 1'b0; mcfg[d][1] = 1'b0;
    end
    g = 14'($urandom);
    model(2'b01, g); load(2'b01, g); wait_done(1); cmp("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
